// File: rtl/syn_update_scheduler.sv
// Synaptic SRAM sequencer: read-wait-write weight-update sweep plus host read arbitration.
// Optional build macro SYN_UPD_SKIP_ZERO_EN adds a per-row spike-count check that skips silent rows.
module syn_update_scheduler #(
    parameter int INPUT_NEURON         = 784,
    parameter int OUTPUT_NEURON        = 256,
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int PRE_NEUR_DATA_WIDTH  = 8,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            UPD_START,
    input  logic                            UPD_ABORT,
    input  logic                            IS_TRAIN,
    input  logic                            HOST_RD_REQ,
    input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] HOST_RD_ADDR,
    output logic                            HOST_RD_GNT,
    input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT,
    output logic                            CTRL_SYNARRAY_CS,
    output logic                            CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEUR_ADDR,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic                            UPD_BUSY,
    output logic                            UPD_DONE
);

    localparam int POST_GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;

    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  LAST_ROW   = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP  = POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] LAST_POST  =
        POST_NEUR_ADDR_WIDTH'((POST_GROUPS - 1) * POST_NEUR_PARALLEL);
    localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] ROW_STRIDE = SYN_ARRAY_ADDR_WIDTH'(POST_GROUPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE,
        S_PRE_CHK
    } state_t;

`ifdef SYN_UPD_SKIP_ZERO_EN
    localparam state_t ROW_FIRST = S_PRE_CHK;
`else
    localparam state_t ROW_FIRST = S_RD;
    logic unused_pre_cnt;
    assign unused_pre_cnt = ^PRE_NEUR_S_CNT;
`endif

    state_t                            state, state_nxt;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]    row, row_nxt;
    // Group base kept as a running post-neuron address so no multiplier is needed.
    logic [POST_NEUR_ADDR_WIDTH-1:0]   post_base, post_nxt;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0]   lin_addr, lin_nxt;
    logic                              last_grp;
    logic                              start_ok;

    assign last_grp = (post_base == LAST_POST);
    assign start_ok = UPD_START && IS_TRAIN;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        post_nxt  = post_base;
        lin_nxt   = lin_addr;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = ROW_FIRST;
                    row_nxt   = '0;
                    post_nxt  = '0;
                    lin_nxt   = '0;
                end
            end
            S_RD:   state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_WR;
            S_WR: begin
                lin_nxt = lin_addr + 1'b1;
                if (last_grp && row == LAST_ROW) begin
                    state_nxt = S_DONE;
                end else if (last_grp) begin
                    state_nxt = ROW_FIRST;
                    row_nxt   = row + 1'b1;
                    post_nxt  = '0;
                end else begin
                    state_nxt = S_RD;
                    post_nxt  = post_base + POST_STEP;
                end
            end
`ifdef SYN_UPD_SKIP_ZERO_EN
            S_PRE_CHK: begin
                // A silent pre-neuron leaves every weight of its row unchanged.
                if (PRE_NEUR_S_CNT == '0) begin
                    if (row == LAST_ROW) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_PRE_CHK;
                        row_nxt   = row + 1'b1;
                        lin_nxt   = lin_addr + ROW_STRIDE;
                    end
                end else begin
                    state_nxt = S_RD;
                end
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (UPD_ABORT && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        HOST_RD_GNT              = 1'b0;
        CTRL_SYNARRAY_CS         = 1'b0;
        CTRL_SYNARRAY_WE         = 1'b0;
        CTRL_SYNARRAY_ADDR       = '0;
        CTRL_PRE_NEUR_ADDR       = '0;
        CTRL_POST_NEURON_ADDRESS = '0;
        UPD_BUSY                 = (state != S_IDLE);
        UPD_DONE                 = 1'b0;
        case (state)
            S_IDLE: begin
                // A starting sweep owns the port first; the host keeps requesting.
                if (!RST && HOST_RD_REQ && !start_ok) begin
                    HOST_RD_GNT        = 1'b1;
                    CTRL_SYNARRAY_CS   = 1'b1;
                    CTRL_SYNARRAY_ADDR = HOST_RD_ADDR;
                end
            end
            S_RD, S_WAIT, S_WR: begin
                CTRL_SYNARRAY_CS         = (state != S_WAIT);
                CTRL_SYNARRAY_WE         = (state == S_WR);
                CTRL_SYNARRAY_ADDR       = lin_addr;
                CTRL_PRE_NEUR_ADDR       = row;
                CTRL_POST_NEURON_ADDRESS = post_base;
            end
            S_PRE_CHK: CTRL_PRE_NEUR_ADDR = row;
            S_DONE:    UPD_DONE = 1'b1;
            default:   UPD_DONE = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            row       <= '0;
            post_base <= '0;
            lin_addr  <= '0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            post_base <= post_nxt;
            lin_addr  <= lin_nxt;
        end
    end

endmodule

// File: tb/tb_syn_update_scheduler.sv
// Directed bench for syn_update_scheduler in a 3x8 configuration (6 words, 2 groups per row).
// Cycle tables cover reset, host arbitration, sweeps, abort and reset; a monitored sweep checks write order.
module tb_syn_update_scheduler;

    localparam int IN_N   = 3;
    localparam int OUT_N  = 8;
    localparam int PAR    = 4;
    localparam int GROUPS = OUT_N / PAR;

    logic        CLK = 1'b0;
    logic        RST;
    logic        UPD_START, UPD_ABORT, IS_TRAIN, HOST_RD_REQ;
    logic [15:0] HOST_RD_ADDR;
    logic        HOST_RD_GNT;
    logic [7:0]  PRE_NEUR_S_CNT;
    logic        CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE;
    logic [15:0] CTRL_SYNARRAY_ADDR;
    logic [9:0]  CTRL_PRE_NEUR_ADDR, CTRL_POST_NEURON_ADDRESS;
    logic        UPD_BUSY, UPD_DONE;

    logic [7:0]  pre_cnt [IN_N];

    always #5 CLK = ~CLK;

    // Spike-count source seen by the scheduler, addressed by the current row.
    always_comb begin
        int idx;
        idx = int'(CTRL_PRE_NEUR_ADDR);
        PRE_NEUR_S_CNT = (idx < IN_N) ? pre_cnt[idx] : 8'd0;
    end

    syn_update_scheduler #(
        .INPUT_NEURON(IN_N),
        .OUTPUT_NEURON(OUT_N),
        .POST_NEUR_PARALLEL(PAR)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .UPD_START(UPD_START),
        .UPD_ABORT(UPD_ABORT),
        .IS_TRAIN(IS_TRAIN),
        .HOST_RD_REQ(HOST_RD_REQ),
        .HOST_RD_ADDR(HOST_RD_ADDR),
        .HOST_RD_GNT(HOST_RD_GNT),
        .PRE_NEUR_S_CNT(PRE_NEUR_S_CNT),
        .CTRL_SYNARRAY_CS(CTRL_SYNARRAY_CS),
        .CTRL_SYNARRAY_WE(CTRL_SYNARRAY_WE),
        .CTRL_SYNARRAY_ADDR(CTRL_SYNARRAY_ADDR),
        .CTRL_PRE_NEUR_ADDR(CTRL_PRE_NEUR_ADDR),
        .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS),
        .UPD_BUSY(UPD_BUSY),
        .UPD_DONE(UPD_DONE)
    );

    typedef struct {
        logic        rst, start, train, abort, hreq;
        logic [15:0] haddr;
        logic        cs, we;
        logic [15:0] addr;
        logic [9:0]  pre, post;
        logic        busy, done, gnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, start, train, abort, hreq, input logic [15:0] haddr,
                                input logic cs, we, input logic [15:0] addr, input logic [9:0] pre, post,
                                input logic busy, done, gnt);
        vec_t v;
        v.rst = rst; v.start = start; v.train = train; v.abort = abort; v.hreq = hreq; v.haddr = haddr;
        v.cs = cs; v.we = we; v.addr = addr; v.pre = pre; v.post = post;
        v.busy = busy; v.done = done; v.gnt = gnt;
        vecs.push_back(v);
    endfunction

    // Idle cycle: the host is granted unless reset is high or a training start claims the port.
    function automatic void add_idle(input logic rst, start, train, hreq, input logic [15:0] haddr);
        logic g;
        g = !rst && hreq && !(start && train);
        add(rst, start, train, 1'b0, hreq, haddr, g, 1'b0, g ? haddr : 16'h0, 10'd0, 10'd0, 1'b0, 1'b0, g);
    endfunction

    // One swept word: RD, WAIT, WR at address row*GROUPS+grp; kill_ph (1..3) asserts abort or
    // reset in that phase and drops the phases after it.
    function automatic void add_word(input int w, input logic hreq, input logic [15:0] haddr,
                                     input logic start_rd, input int kill_ph, input logic kill_rst);
        int row, grp;
        logic k;
        row = w / GROUPS;
        grp = w % GROUPS;
`ifdef SYN_UPD_SKIP_ZERO_EN
        if (grp == 0)
            add(1'b0, 1'b0, 1'b1, 1'b0, hreq, haddr, 1'b0, 1'b0, 16'h0, 10'(row), 10'd0, 1'b1, 1'b0, 1'b0);
`endif
        for (int ph = 1; ph <= 3; ph++) begin
            k = (ph == kill_ph);
            add(k && kill_rst, start_rd && ph == 1, 1'b1, k && !kill_rst, hreq, haddr,
                ph != 2, ph == 3, 16'(w), 10'(row), 10'(grp * PAR), 1'b1, 1'b0, 1'b0);
            if (k) return;
        end
    endfunction

    function automatic void add_done(input logic hreq, input logic [15:0] haddr);
        add(1'b0, 1'b0, 1'b0, 1'b0, hreq, haddr, 1'b0, 1'b0, 16'h0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_k, nw, wk;
        logic        cs_h [0:63];
        logic        we_h [0:63];
        logic [15:0] ad_h [0:63];
        logic [15:0] exp_wr[$];
        int          exp_done;

        for (int i = 0; i < IN_N; i++) pre_cnt[i] = 8'd1;
        RST = 1'b1; UPD_START = 1'b0; UPD_ABORT = 1'b0; IS_TRAIN = 1'b0;
        HOST_RD_REQ = 1'b0; HOST_RD_ADDR = 16'h0;

        // Reset holds outputs low even with a host request pending.
        add_idle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0055);
        add_idle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        add_idle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);   // start without IS_TRAIN is ignored
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Start beats a simultaneous host request; the host keeps asking through the sweep.
        add_idle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0123);
        for (int w = 0; w < IN_N * GROUPS; w++) add_word(w, 1'b1, 16'h0123, w == 2, 0, 1'b0);
        add_done(1'b1, 16'h0123);
        add_idle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Abort in WAIT of word 5: no write, no done.
        add_idle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        for (int w = 0; w < 5; w++) add_word(w, 1'b0, 16'h0, 1'b0, 0, 1'b0);
        add_word(5, 1'b0, 16'h0, 1'b0, 2, 1'b0);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Abort in WR of word 1: the write is still issued.
        add_idle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        add_word(0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
        add_word(1, 1'b0, 16'h0, 1'b0, 3, 1'b0);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Reset held two cycles starting in RD of word 1.
        add_idle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        add_word(0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
        add_word(1, 1'b0, 16'h0, 1'b0, 1, 1'b1);
        add_idle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0077);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        @(posedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            RST = vecs[i].rst; UPD_START = vecs[i].start; IS_TRAIN = vecs[i].train;
            UPD_ABORT = vecs[i].abort; HOST_RD_REQ = vecs[i].hreq; HOST_RD_ADDR = vecs[i].haddr;
            @(negedge CLK);
            check($sformatf("vec%0d", i),
                  64'({CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_NEUR_ADDR,
                       CTRL_POST_NEURON_ADDRESS, UPD_BUSY, UPD_DONE, HOST_RD_GNT}),
                  64'({vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].pre, vecs[i].post,
                       vecs[i].busy, vecs[i].done, vecs[i].gnt}));
            @(posedge CLK);
        end

        // Monitored full sweep: write order, RD two cycles before each WR, done latency.
`ifdef SYN_UPD_SKIP_ZERO_EN
        pre_cnt[0] = 8'd0; pre_cnt[1] = 8'd7; pre_cnt[2] = 8'd0;
        exp_wr = '{16'd2, 16'd3};
        exp_done = 10;
`else
        exp_wr = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        exp_done = 19;
`endif
        #1;
        RST = 1'b0; UPD_START = 1'b1; IS_TRAIN = 1'b1; UPD_ABORT = 1'b0; HOST_RD_REQ = 1'b0;
        @(posedge CLK);
        #1 UPD_START = 1'b0;
        done_k = 0;
        nw = 0;
        for (int k = 1; k < 60; k++) begin
            @(negedge CLK);
            cs_h[k] = CTRL_SYNARRAY_CS;
            we_h[k] = CTRL_SYNARRAY_WE;
            ad_h[k] = CTRL_SYNARRAY_ADDR;
            if (CTRL_SYNARRAY_WE) begin
                wk = k;
                if (nw < exp_wr.size())
                    check($sformatf("wr_addr%0d", nw), 64'(CTRL_SYNARRAY_ADDR), 64'(exp_wr[nw]));
                if (wk >= 3)
                    check($sformatf("rd_before_wr%0d", nw), 64'({cs_h[wk-2], we_h[wk-2], ad_h[wk-2]}),
                          64'({1'b1, 1'b0, CTRL_SYNARRAY_ADDR}));
                nw++;
            end
            if (UPD_DONE) begin
                done_k = k;
                break;
            end
        end
        check("done_cycle", 64'(done_k), 64'(exp_done));
        check("n_writes", 64'(nw), 64'(exp_wr.size()));
        @(negedge CLK);
        check("idle_after_done", 64'({UPD_BUSY, UPD_DONE, CTRL_SYNARRAY_CS}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
